// File: rtl/clk_pkg.sv
// clk_pkg: shared state type, phase-delay helper and clock constants for clk_divider.
package clk_pkg;
    typedef enum logic {PHASE_WAIT, RUN} state_t;
    localparam int CLK_IN_MHZ_DEFAULT = 100;
    // 64-bit intermediate so phase_deg*2*div cannot overflow for large dividers.
    function automatic int phase_cycles(input int phase_deg, input int div);
        return int'((longint'(phase_deg) * 2 * longint'(div)) / 360);
    endfunction
endpackage

// File: rtl/clk_divider_if.sv
// clk_divider_if: divided clock and lock status bundle driven by clk_divider.
interface clk_divider_if;
    logic clk_out1;
    logic LOCKED;
    modport master (output clk_out1, output LOCKED);
    modport slave (input clk_out1, input LOCKED);
endinterface

// File: rtl/clk_divider.sv
// clk_divider: fabric counter producing a 50% duty clk_out1 = clk_in/(2*DIVIDER1),
// with an optional startup phase delay and a sticky LOCKED flag.
module clk_divider
    import clk_pkg::*;
#(
    parameter int DIVIDER1 = 5208,
    parameter int BASE_FREQUENCY = CLK_IN_MHZ_DEFAULT,
    parameter int PHASE_SHIFT = 0
) (
    input logic clk_in,
    input logic rst_n,
    clk_divider_if.master bus
);
    localparam int P = phase_cycles(PHASE_SHIFT, DIVIDER1);
    localparam int CW = $clog2(DIVIDER1) + 1;
    localparam int PW = $clog2(P + 1) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIVIDER1 - 1);
    localparam logic [PW-1:0] PH_MAX = PW'((P > 0) ? P - 1 : 0);
    localparam state_t RST_STATE = (P > 0) ? PHASE_WAIT : RUN;
    if (DIVIDER1 < 1) begin : g_bad_div
        $fatal(1, "clk_divider: DIVIDER1 must be >= 1");
    end
    if (PHASE_SHIFT < 0 || PHASE_SHIFT > 359) begin : g_bad_phase
        $fatal(1, "clk_divider: PHASE_SHIFT must be in 0..359");
    end
    if (BASE_FREQUENCY == 0) begin : g_bad_freq
        $fatal(1, "clk_divider: BASE_FREQUENCY must be nonzero");
    end
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] ph_q, ph_d;
    logic clk_q, clk_d;
    logic locked_q, locked_d;
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RST_STATE;
            cnt_q    <= '0;
            ph_q     <= '0;
            clk_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ph_q     <= ph_d;
            clk_q    <= clk_d;
            locked_q <= locked_d;
        end
    end
    // LOCKED latches on the first high-to-low toggle, so it is stable at every later rising edge.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ph_d     = ph_q;
        clk_d    = clk_q;
        locked_d = locked_q;
        if (state_q == PHASE_WAIT) begin
            ph_d = ph_q + 1'b1;
            if (ph_q == PH_MAX) begin
                state_d = RUN;
                cnt_d   = '0;
            end
        end else if (cnt_q == CNT_MAX) begin
            cnt_d    = '0;
            clk_d    = ~clk_q;
            locked_d = locked_q | clk_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end
    assign bus.clk_out1 = clk_q;
    assign bus.LOCKED   = locked_q;
endmodule

// File: tb/tb_clk_divider.sv
// tb_clk_divider: directed checks of clk_divider edge timing, phase delay, async reset and defaults.
module tb_clk_divider;
    logic clk = 1'b0;
    logic [3:0] rst_n = 4'b0000;
    logic [3:0] co, lk;
    int errors = 0;
    int checks = 0;
    always #5 clk = ~clk;
    clk_divider_if if0 ();
    clk_divider_if if1 ();
    clk_divider_if if2 ();
    clk_divider_if if3 ();
    clk_divider #(.DIVIDER1(4), .BASE_FREQUENCY(100), .PHASE_SHIFT(0)) u_d4 (.clk_in(clk), .rst_n(rst_n[0]), .bus(if0));
    clk_divider #(.DIVIDER1(1), .BASE_FREQUENCY(100), .PHASE_SHIFT(0)) u_d1 (.clk_in(clk), .rst_n(rst_n[1]), .bus(if1));
    clk_divider #(.DIVIDER1(4), .BASE_FREQUENCY(100), .PHASE_SHIFT(90)) u_p90 (.clk_in(clk), .rst_n(rst_n[2]), .bus(if2));
    clk_divider u_def (.clk_in(clk), .rst_n(rst_n[3]), .bus(if3));
    assign co[0] = if0.clk_out1;
    assign co[1] = if1.clk_out1;
    assign co[2] = if2.clk_out1;
    assign co[3] = if3.clk_out1;
    assign lk[0] = if0.LOCKED;
    assign lk[1] = if1.LOCKED;
    assign lk[2] = if2.LOCKED;
    assign lk[3] = if3.LOCKED;

    // Edge k counts rising edges after release: output rises at p+d, then toggles every d edges.
    task automatic check_seq(input int id, input int p, input int d, input int n, input string name);
        logic exp_c, exp_l;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            exp_c = (k < p + d) ? 1'b0 : (((k - p - d) / d) % 2 == 0);
            exp_l = (k >= p + 2 * d);
            checks += 2;
            if (co[id] !== exp_c) begin
                errors++;
                $display("FAIL %s clk_out1 edge %0d: got %b want %b", name, k, co[id], exp_c);
            end
            if (lk[id] !== exp_l) begin
                errors++;
                $display("FAIL %s LOCKED edge %0d: got %b want %b", name, k, lk[id], exp_l);
            end
        end
    endtask

    task automatic test_reset();
        #2;
        for (int i = 0; i < 4; i++) begin
            checks += 2;
            if (co[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset clk_out1[%0d]: got %b want 0", i, co[i]);
            end
            if (lk[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset LOCKED[%0d]: got %b want 0", i, lk[i]);
            end
        end
    endtask

    task automatic test_div4();
        @(negedge clk);
        rst_n[0] = 1'b1;
        check_seq(0, 0, 4, 24, "div4");
    endtask

    task automatic test_div1();
        @(negedge clk);
        rst_n[1] = 1'b1;
        check_seq(1, 0, 1, 8, "div1");
    endtask

    task automatic test_phase90();
        @(negedge clk);
        rst_n[2] = 1'b1;
        check_seq(2, 2, 4, 26, "phase90");
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        rst_n[0] = 1'b0;
        @(negedge clk);
        rst_n[0] = 1'b1;
        check_seq(0, 0, 4, 12, "pre_reset");
        @(posedge clk);
        #1;
        checks++;
        if (co[0] !== 1'b1) begin
            errors++;
            $display("FAIL async_pre clk_out1 edge 13: got %b want 1", co[0]);
        end
        #2;
        rst_n[0] = 1'b0;
        #1;
        checks += 2;
        if (co[0] !== 1'b0) begin
            errors++;
            $display("FAIL async clk_out1: got %b want 0", co[0]);
        end
        if (lk[0] !== 1'b0) begin
            errors++;
            $display("FAIL async LOCKED: got %b want 0", lk[0]);
        end
        @(negedge clk);
        rst_n[0] = 1'b1;
        check_seq(0, 0, 4, 12, "post_reset");
    endtask

    task automatic test_default();
        int rise1, fall1, rise2, lock_e;
        logic prev;
        rise1 = -1;
        fall1 = -1;
        rise2 = -1;
        lock_e = -1;
        prev = 1'b0;
        @(negedge clk);
        rst_n[3] = 1'b1;
        for (int k = 1; k <= 22000 && rise2 < 0; k++) begin
            @(posedge clk);
            #1;
            if (lk[3] === 1'b1 && lock_e < 0) lock_e = k;
            if (co[3] === 1'b1 && prev === 1'b0) begin
                if (rise1 < 0) rise1 = k;
                else rise2 = k;
            end
            if (co[3] === 1'b0 && prev === 1'b1 && fall1 < 0) fall1 = k;
            prev = co[3];
        end
        checks += 5;
        if (rise1 !== 5208) begin
            errors++;
            $display("FAIL default first_rise: got %0d want 5208", rise1);
        end
        if (fall1 !== 10416) begin
            errors++;
            $display("FAIL default first_fall: got %0d want 10416", fall1);
        end
        if (lock_e !== 10416) begin
            errors++;
            $display("FAIL default locked_edge: got %0d want 10416", lock_e);
        end
        if (rise2 - rise1 !== 10416) begin
            errors++;
            $display("FAIL default period: got %0d want 10416", rise2 - rise1);
        end
        if (fall1 - rise1 !== 5208) begin
            errors++;
            $display("FAIL default high_time: got %0d want 5208", fall1 - rise1);
        end
    endtask

    initial begin
        test_reset();
        test_div4();
        test_div1();
        test_phase90();
        test_async_reset();
        test_default();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
